// File: rtl/smart_toilet_dose_sequencer.sv
// Smart-toilet assay dose sequencer: staggered reagent pumps,
// co-flow, settle, detector req/ack handshake, then chip flush.
module smart_toilet_dose_sequencer #(
  parameter int CNT_W    = 16,
  parameter int T_LEAD3  = 900,
  parameter int T_LEAD2  = 400,
  parameter int T_COFLOW = 300,
  parameter int T_SETTLE = 200,
  parameter int T_ACK_TO = 1000,
  parameter int T_FLUSH  = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic sample_ack,
  output logic pump1_en,
  output logic pump2_en,
  output logic pump3_en,
  output logic flush_en,
  output logic sample_req,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE, LEAD3, LEAD2, COFLOW,
    SETTLE, SAMPLE, FLUSH
  } state_t;

  localparam int M1 =
    (T_LEAD3 > T_LEAD2) ? T_LEAD3 : T_LEAD2;
  localparam int M2 =
    (T_COFLOW > T_SETTLE) ? T_COFLOW : T_SETTLE;
  localparam int M3 =
    (T_ACK_TO > T_FLUSH) ? T_ACK_TO : T_FLUSH;
  localparam int M4 = (M1 > M2) ? M1 : M2;
  localparam int TMAX = (M4 > M3) ? M4 : M3;

  localparam int TMIN_OK =
    (T_LEAD3 >= 1) && (T_LEAD2 >= 1) &&
    (T_COFLOW >= 1) && (T_SETTLE >= 1) &&
    (T_ACK_TO >= 1) && (T_FLUSH >= 1);

  if ((CNT_W < 1) || (TMIN_OK == 0) ||
      (longint'(TMAX - 1) >=
       (longint'(1) << CNT_W))) begin : g_bad_cfg
    $error("timer too narrow or zero phase");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] tmr, tmr_ld;
  logic             tmr_zero;
  logic             tmo;
  logic             p1_d, p2_d, p3_d;
  logic             fl_d, rq_d;
  logic             busy_d, done_d, err_d;

  assign tmr_zero = (tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmr        <= '0;
      pump1_en   <= 1'b0;
      pump2_en   <= 1'b0;
      pump3_en   <= 1'b0;
      flush_en   <= 1'b0;
      sample_req <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)
        tmr <= tmr_ld;
      else if (!tmr_zero)
        tmr <= tmr - CNT_W'(1);
      pump1_en   <= p1_d;
      pump2_en   <= p2_d;
      pump3_en   <= p3_d;
      flush_en   <= fl_d;
      sample_req <= rq_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // abort outranks both ack and the ack timeout
  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    unique case (state)
      IDLE:
        if (start) state_n = LEAD3;
      LEAD3:
        if (abort) state_n = FLUSH;
        else if (tmr_zero) state_n = LEAD2;
      LEAD2:
        if (abort) state_n = FLUSH;
        else if (tmr_zero) state_n = COFLOW;
      COFLOW:
        if (abort) state_n = FLUSH;
        else if (tmr_zero) state_n = SETTLE;
      SETTLE:
        if (abort) state_n = FLUSH;
        else if (tmr_zero) state_n = SAMPLE;
      SAMPLE:
        if (abort || sample_ack) begin
          state_n = FLUSH;
        end else if (tmr_zero) begin
          state_n = FLUSH;
          tmo     = 1'b1;
        end
      FLUSH:
        if (tmr_zero) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    tmr_ld = '0;
    unique case (state_n)
      LEAD3:   tmr_ld = CNT_W'(T_LEAD3 - 1);
      LEAD2:   tmr_ld = CNT_W'(T_LEAD2 - 1);
      COFLOW:  tmr_ld = CNT_W'(T_COFLOW - 1);
      SETTLE:  tmr_ld = CNT_W'(T_SETTLE - 1);
      SAMPLE:  tmr_ld = CNT_W'(T_ACK_TO - 1);
      FLUSH:   tmr_ld = CNT_W'(T_FLUSH - 1);
      default: tmr_ld = '0;
    endcase
  end

  always_comb begin
    p1_d = 1'b0;
    p2_d = 1'b0;
    p3_d = 1'b0;
    fl_d = 1'b0;
    rq_d = 1'b0;
    unique case (state_n)
      LEAD3: p3_d = 1'b1;
      LEAD2: begin
        p3_d = 1'b1;
        p2_d = 1'b1;
      end
      COFLOW: begin
        p3_d = 1'b1;
        p2_d = 1'b1;
        p1_d = 1'b1;
      end
      SAMPLE:  rq_d = 1'b1;
      FLUSH:   fl_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_n != IDLE);
    done_d = (state == FLUSH) &&
             (state_n == IDLE);
    unique case (1'b1)
      tmo:
        err_d = 1'b1;
      (state == IDLE) && start:
        err_d = 1'b0;
      default:
        err_d = err;
    endcase
  end

endmodule
